// File: rtl/sc_game_pkg.sv
// Shared state encoding and screen codes for the game sequencer and the matrix mux.
package sc_game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BANNER   = 3'd1,
    LOAD_CLR = 3'd2,
    LOAD_SET = 3'd3,
    PLAY     = 3'd4,
    WIN      = 3'd5,
    LOSS     = 3'd6
  } state_t;

  localparam logic [2:0] SCREEN_GAME   = 3'd0;
  localparam logic [2:0] SCREEN_LEVEL1 = 3'd1;
  localparam logic [2:0] SCREEN_LEVEL2 = 3'd2;
  localparam logic [2:0] SCREEN_LEVEL3 = 3'd3;
  localparam logic [2:0] SCREEN_WIN    = 3'd4;
  localparam logic [2:0] SCREEN_LOSS   = 3'd5;
  localparam logic [2:0] SCREEN_BLANK  = 3'd7;

  // Banner screen codes line up with the level number.
  function automatic logic [2:0] level_screen(input logic [1:0] level);
    return {1'b0, level};
  endfunction

endpackage

// File: rtl/sc_bannertimer.sv
// Counts tick pulses while enabled; o_done fires on the tick that completes BANNER_TICKS.
module sc_bannertimer #(
  parameter int BANNER_TICKS        = 8,
  parameter int TICKCOUNT_DATAWIDTH = 4
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  localparam logic [TICKCOUNT_DATAWIDTH-1:0] LAST_COUNT = TICKCOUNT_DATAWIDTH'(BANNER_TICKS - 1);

  logic [TICKCOUNT_DATAWIDTH-1:0] r_count;

  assign o_done = i_enable && (r_count == LAST_COUNT);

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear || o_done) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/sc_statemachine_game.sv
// Game flow sequencer: banner, level load strobes, play, win/loss, with level and lives tracking.
module sc_statemachine_game
  import sc_game_pkg::*;
#(
  parameter int LEVELS              = 3,
  parameter int LIVES               = 3,
  parameter int BANNER_TICKS        = 8,
  parameter int TICKCOUNT_DATAWIDTH = 4
) (
  input  logic       SC_STATEMACHINEGAME_CLOCK_50,
  input  logic       SC_STATEMACHINEGAME_RESET_InHigh,
  input  logic       SC_STATEMACHINEGAME_start_In,
  input  logic       SC_STATEMACHINEGAME_tick_In,
  input  logic       SC_STATEMACHINEGAME_collision_In,
  input  logic       SC_STATEMACHINEGAME_levelDone_In,
  output logic [2:0] SC_STATEMACHINEGAME_screen_Out,
  output logic [1:0] SC_STATEMACHINEGAME_level_Out,
  output logic [1:0] SC_STATEMACHINEGAME_lives_Out,
  output logic       SC_STATEMACHINEGAME_clear_Out,
  output logic       SC_STATEMACHINEGAME_load_Out,
  output logic       SC_STATEMACHINEGAME_play_Out
);

  localparam logic [1:0] LEVEL_LAST = 2'(LEVELS);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_level;
  logic [1:0] w_level_next;
  logic [1:0] r_lives;
  logic [1:0] w_lives_next;
  logic       r_start_q;
  logic       r_rst_q;
  logic       w_start_edge;
  logic       w_banner_done;

  // r_rst_q masks the first post-reset cycle so a button held through reset gives no edge.
  assign w_start_edge = SC_STATEMACHINEGAME_start_In & ~r_start_q & ~r_rst_q;

  sc_bannertimer #(
    .BANNER_TICKS        (BANNER_TICKS),
    .TICKCOUNT_DATAWIDTH (TICKCOUNT_DATAWIDTH)
  ) u_bannertimer (
    .i_clk    (SC_STATEMACHINEGAME_CLOCK_50),
    .i_srst   (SC_STATEMACHINEGAME_RESET_InHigh),
    .i_clear  (r_state != BANNER),
    .i_enable ((r_state == BANNER) && SC_STATEMACHINEGAME_tick_In),
    .o_done   (w_banner_done)
  );

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      r_state   <= IDLE;
      r_level   <= 2'd1;
      r_lives   <= LIVES_INIT;
      r_start_q <= 1'b0;
      r_rst_q   <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_level   <= w_level_next;
      r_lives   <= w_lives_next;
      r_start_q <= SC_STATEMACHINEGAME_start_In;
      r_rst_q   <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_lives_next = r_lives;
    case (r_state)
      IDLE, WIN, LOSS: begin
        if (w_start_edge) begin
          w_state_next = BANNER;
          w_level_next = 2'd1;
          w_lives_next = LIVES_INIT;
        end
      end
      BANNER: begin
        if (w_banner_done) w_state_next = LOAD_CLR;
      end
      LOAD_CLR: w_state_next = LOAD_SET;
      LOAD_SET: w_state_next = PLAY;
      PLAY: begin
        // Collision outranks level completion when both arrive together.
        if (SC_STATEMACHINEGAME_collision_In) begin
          if (r_lives > 2'd1) begin
            w_lives_next = r_lives - 2'd1;
            w_state_next = BANNER;
          end else begin
            w_lives_next = 2'd0;
            w_state_next = LOSS;
          end
        end else if (SC_STATEMACHINEGAME_levelDone_In) begin
          if (r_level < LEVEL_LAST) begin
            w_level_next = r_level + 2'd1;
            w_state_next = BANNER;
          end else begin
            w_state_next = WIN;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    SC_STATEMACHINEGAME_screen_Out = SCREEN_BLANK;
    SC_STATEMACHINEGAME_clear_Out  = 1'b0;
    SC_STATEMACHINEGAME_load_Out   = 1'b0;
    SC_STATEMACHINEGAME_play_Out   = 1'b0;
    case (r_state)
      BANNER:   SC_STATEMACHINEGAME_screen_Out = level_screen(r_level);
      LOAD_CLR: SC_STATEMACHINEGAME_clear_Out  = 1'b1;
      LOAD_SET: SC_STATEMACHINEGAME_load_Out   = 1'b1;
      PLAY: begin
        SC_STATEMACHINEGAME_screen_Out = SCREEN_GAME;
        SC_STATEMACHINEGAME_play_Out   = 1'b1;
      end
      WIN:      SC_STATEMACHINEGAME_screen_Out = SCREEN_WIN;
      LOSS:     SC_STATEMACHINEGAME_screen_Out = SCREEN_LOSS;
      default:  SC_STATEMACHINEGAME_screen_Out = SCREEN_BLANK;
    endcase
  end

  assign SC_STATEMACHINEGAME_level_Out = r_level;
  assign SC_STATEMACHINEGAME_lives_Out = r_lives;

endmodule

// File: tb/tb_sc_statemachine_game.sv
// Directed bench for the game sequencer with a per-cycle reference model of the game flow.
module tb_sc_statemachine_game;

  localparam int BT = 4;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       coll = 1'b0;
  logic       done = 1'b0;
  logic [2:0] screen;
  logic [1:0] level;
  logic [1:0] lives;
  logic       clr;
  logic       load;
  logic       play;

  int n_cmp = 0;
  int n_fail = 0;

  sc_statemachine_game #(
    .LEVELS (3), .LIVES (3), .BANNER_TICKS (BT), .TICKCOUNT_DATAWIDTH (4)
  ) dut (
    .SC_STATEMACHINEGAME_CLOCK_50     (clk),
    .SC_STATEMACHINEGAME_RESET_InHigh (srst),
    .SC_STATEMACHINEGAME_start_In     (start),
    .SC_STATEMACHINEGAME_tick_In      (tick),
    .SC_STATEMACHINEGAME_collision_In (coll),
    .SC_STATEMACHINEGAME_levelDone_In (done),
    .SC_STATEMACHINEGAME_screen_Out   (screen),
    .SC_STATEMACHINEGAME_level_Out    (level),
    .SC_STATEMACHINEGAME_lives_Out    (lives),
    .SC_STATEMACHINEGAME_clear_Out    (clr),
    .SC_STATEMACHINEGAME_load_Out     (load),
    .SC_STATEMACHINEGAME_play_Out     (play)
  );

  always #5 clk = ~clk;

  // Tick pulse every 5 clocks, running in every phase of the game.
  initial begin
    int t = 0;
    forever begin
      @(posedge clk); #1;
      tick = (t == 4);
      t = (t + 1) % 5;
    end
  end

  // Reference model: phases of play, with banner time kept as ticks remaining.
  localparam int P_OFF = 0, P_TITLE = 1, P_WIPE = 2, P_FILL = 3, P_RUN = 4, P_WON = 5, P_LOST = 6;
  int m_phase = P_OFF, m_level = 1, m_lives = 3, m_left = 0;
  bit m_prev = 0, m_fresh = 1, m_valid = 0;

  always @(posedge clk) begin
    if (srst) begin
      m_phase = P_OFF; m_level = 1; m_lives = 3; m_left = 0;
      m_prev = 0; m_fresh = 1; m_valid = 1;
    end else begin
      bit pressed;
      pressed = start && !m_prev && !m_fresh;
      m_prev = start; m_fresh = 0;
      case (m_phase)
        P_OFF, P_WON, P_LOST:
          if (pressed) begin m_phase = P_TITLE; m_level = 1; m_lives = 3; m_left = BT; end
        P_TITLE:
          if (tick) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = P_WIPE;
          end
        P_WIPE: m_phase = P_FILL;
        P_FILL: m_phase = P_RUN;
        P_RUN:
          if (coll) begin
            if (m_lives > 1) begin m_lives = m_lives - 1; m_phase = P_TITLE; m_left = BT; end
            else begin m_lives = 0; m_phase = P_LOST; end
          end else if (done) begin
            if (m_level < 3) begin m_level = m_level + 1; m_phase = P_TITLE; m_left = BT; end
            else m_phase = P_WON;
          end
        default: m_phase = P_OFF;
      endcase
    end
  end

  function automatic int exp_screen();
    case (m_phase)
      P_TITLE: return m_level;
      P_RUN:   return 0;
      P_WON:   return 4;
      P_LOST:  return 5;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_screen", int'(screen), exp_screen());
      chk("m_level", int'(level), m_level);
      chk("m_lives", int'(lives), m_lives);
      chk("m_clear", int'(clr), int'(m_phase == P_WIPE));
      chk("m_load", int'(load), int'(m_phase == P_FILL));
      chk("m_play", int'(play), int'(m_phase == P_RUN));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_play();
    int k = 0;
    while (!play && k < 200) begin cyc(1); k++; end
    chk("wait_play", int'(play), 1);
  endtask

  task automatic press();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic hit(input bit c, input bit d);
    coll = c; done = d; cyc(1); coll = 1'b0; done = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    srst = 1'b1; cyc(1);
    chk({tag, "_screen"}, int'(screen), 7);
    chk({tag, "_strobes"}, int'({clr, load, play}), 0);
    chk({tag, "_level"}, int'(level), 1);
    chk({tag, "_lives"}, int'(lives), 3);
    srst = 1'b0;
  endtask

  initial begin
    int n, k, scr;
    // 1: start held through reset, then a clean edge and a full banner/load sequence
    cyc(1); start = 1'b1; cyc(2);
    srst = 1'b0; cyc(4);
    chk("held_through_reset", int'(screen), 7);
    start = 1'b0; cyc(1); start = 1'b1; cyc(1);
    chk("start_screen", int'(screen), 1);
    chk("start_level", int'(level), 1);
    chk("start_lives", int'(lives), 3);
    cyc(10); start = 1'b0;
    wait_play();
    chk("play_screen", int'(screen), 0);
    start = 1'b1; cyc(2); start = 1'b0; cyc(1);
    chk("start_in_play", int'(screen), 0);

    // 2: level progression to WIN
    hit(0, 1);
    chk("lvl2_screen", int'(screen), 2);
    chk("lvl2_level", int'(level), 2);
    wait_play(); hit(0, 1);
    chk("lvl3_screen", int'(screen), 3);
    wait_play(); hit(0, 1);
    chk("win_screen", int'(screen), 4);
    chk("win_play", int'(play), 0);
    chk("win_level", int'(level), 3);

    // 6: noise in WIN, then restart
    coll = 1'b1; done = 1'b1; cyc(12); coll = 1'b0; done = 1'b0;
    chk("win_hold", int'(screen), 4);
    press();
    chk("restart_screen", int'(screen), 1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_level", int'(level), 1);

    // 4: simultaneous collision and level done
    wait_play(); hit(1, 1);
    chk("both_lives", int'(lives), 2);
    chk("both_level", int'(level), 1);
    chk("both_screen", int'(screen), 1);
    wait_play(); hit(1, 0);
    chk("coll_lives1", int'(lives), 1);
    wait_play(); hit(1, 0);
    chk("loss_screen", int'(screen), 5);
    chk("loss_lives", int'(lives), 0);
    coll = 1'b1; done = 1'b1; cyc(12); coll = 1'b0; done = 1'b0;
    chk("loss_hold", int'(screen), 5);

    // 3: three collisions from a fresh game
    press();
    chk("loss_restart_lives", int'(lives), 3);
    for (int i = 0; i < 3; i++) begin
      wait_play(); hit(1, 0);
      chk("coll_seq_lives", int'(lives), (i < 2) ? 2 - i : 0);
      chk("coll_seq_screen", int'(screen), (i < 2) ? 1 : 5);
    end

    // 5: reset after two banner ticks, then a full-length banner
    press();
    n = 0; k = 0;
    while (n < 2 && k < 100) begin
      @(posedge clk);
      if (tick) n++;
      k++; #1;
    end
    chk("midbanner_ticks", n, 2);
    reset_check("rst_banner");
    cyc(2); press();
    n = 0; k = 0; scr = int'(screen);
    while (!clr && k < 200) begin
      @(posedge clk);
      if (tick && scr >= 1 && scr <= 3) n++;
      #1; scr = int'(screen); k++;
    end
    chk("full_banner_ticks", n, BT);
    wait_play(); cyc(3);
    reset_check("rst_play");
    coll = 1'b1; done = 1'b1; cyc(12); coll = 1'b0; done = 1'b0;
    chk("idle_hold", int'(screen), 7);
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_statemachine_game.md
Name: sc_statemachine_game

Overview:
Top-level game sequencer for the 8x8 MAX7219 matrix game.
- Steps through the flow: idle, level banner, level load, play, then win or loss.
- Tracks the current level (1..LEVELS) and the remaining lives.
- Drives the screen-select code that the BB_SYSTEM matrix mux uses to choose between game, level-banner, win, loss and blank images.
- Issues the clear/load strobes consumed by the point, obstacle and house register banks.

Parameters:
LEVELS, 3, number of levels; reaching the last level's goal means win.
LIVES, 3, lives granted at game start.
BANNER_TICKS, 8, tick_In pulses the level banner stays on screen.
TICKCOUNT_DATAWIDTH, 4, width of the banner tick counter; must hold BANNER_TICKS.

Ports:
SC_STATEMACHINEGAME_CLOCK_50  in  1  system clock.
SC_STATEMACHINEGAME_RESET_InHigh  in  1  synchronous reset, active high.
SC_STATEMACHINEGAME_start_In  in  1  debounced start button, active high level.
SC_STATEMACHINEGAME_tick_In  in  1  one-cycle prescaler pulse (game speed).
SC_STATEMACHINEGAME_collision_In  in  1  point overlaps an obstacle (level).
SC_STATEMACHINEGAME_levelDone_In  in  1  all houses of the level reached (level).
SC_STATEMACHINEGAME_screen_Out  out  3  0 GAME, 1 LEVEL1, 2 LEVEL2, 3 LEVEL3, 4 WIN, 5 LOSS, 7 BLANK.
SC_STATEMACHINEGAME_level_Out  out  2  current level, 1..LEVELS.
SC_STATEMACHINEGAME_lives_Out  out  2  remaining lives.
SC_STATEMACHINEGAME_clear_Out  out  1  one-cycle clear strobe to point/obstacle/house registers.
SC_STATEMACHINEGAME_load_Out  out  1  one-cycle load strobe (level init data).
SC_STATEMACHINEGAME_play_Out  out  1  high while in PLAY; enables point movement and speed counter.

Behaviour:
Clock and reset:
- One clock; synchronous active-high reset.
- Reset wins over every other input, including mid-PLAY and mid-banner.

Reset values:
- state IDLE, level 1, lives LIVES, tick counter 0.
- screen_Out 7 (BLANK); clear_Out, load_Out and play_Out all 0.
- Start edge register is cleared to 0.

Start edge:
- startEdge = start_In & ~start_q, where start_q is start_In registered.
- Holding the button gives exactly one edge.
- A button held through reset does not produce an edge on the first cycle after reset.

Outputs:
- All outputs are a Moore decode of registered state, level and lives.
- Each output changes on the clock edge that performs the transition.
- clear_Out and load_Out are asserted only while in the LOAD states.

States:
- IDLE: screen BLANK. On startEdge go to BANNER; level set to 1, lives set to LIVES, tick counter 0.
- BANNER: screen = level code (1..3).
  - Tick counter increments on each tick_In.
  - When tick_In arrives with counter == BANNER_TICKS-1, go to LOAD_CLR.
  - collision_In, levelDone_In and startEdge are ignored.
- LOAD_CLR: exactly 1 cycle; clear_Out=1, screen BLANK; then go to LOAD_SET.
- LOAD_SET: exactly 1 cycle; load_Out=1, screen BLANK; then go to PLAY.
- PLAY: screen GAME, play_Out=1. Inputs are checked in priority order:
  1. collision_In with lives > 1: decrement lives, go to BANNER (same level, counter 0).
  2. collision_In with lives == 1: lives becomes 0, go to LOSS.
  3. levelDone_In with level < LEVELS: increment level, go to BANNER.
  4. levelDone_In with level == LEVELS: go to WIN.
  - Collision has priority when collision_In and levelDone_In are high together.
- WIN / LOSS: screens 4 / 5. level and lives hold their values. On startEdge go to BANNER with level 1 and lives LIVES.

Boundary rules:
- tick_In outside BANNER is ignored.
- The tick counter is cleared on every entry to BANNER.
- Level never exceeds LEVELS; lives never underflow below 0.
- A start press during play does nothing.

Latency examples:
- startEdge sampled at edge N: BANNER visible from N.
- Final banner tick at N: clear_Out high in cycle N..N+1, load_Out high in N+1..N+2, play_Out high from N+2.

Decomposition:
- Shared package sc_game_pkg holds:
  - state encoding: IDLE, BANNER, LOAD_CLR, LOAD_SET, PLAY, WIN, LOSS (3-bit);
  - screen codes SCREEN_GAME, SCREEN_LEVEL1..3, SCREEN_WIN, SCREEN_LOSS, SCREEN_BLANK, reused by the BB_SYSTEM matrix mux.
- One sub-module, sc_bannertimer: a tick counter with clear and enable that produces a done pulse at BANNER_TICKS. The FSM, level/lives registers and output decode stay in the parent.

Test Plan:
(Bench uses BANNER_TICKS=4 and tick_In pulsed every 5 clocks.)
1. Reset, then start rising edge -> screen 7 becomes 1, level 1, lives 3. After 4 ticks: clear_Out pulse 1 cycle, load_Out pulse the next cycle, then screen 0 and play_Out=1. Holding start produces no second transition.
2. In PLAY at level 1, pulse levelDone_In -> level 2, screen 2. Repeat through level 3; levelDone_In at level 3 -> screen 4 (WIN), play_Out=0, level stays 3.
3. In PLAY, collision_In three times, each followed by the banner/load sequence -> lives 3→2→1 with screen returning to the level code each time. The third collision -> screen 5 (LOSS), lives 0.
4. collision_In and levelDone_In high in the same cycle at level 1, lives 3 -> lives 2, level stays 1, screen 1.
5. Reset asserted mid-BANNER (tick counter 2) and mid-PLAY -> next cycle state IDLE, screen 7, all strobes 0, level 1, lives 3. A fresh start runs a full 4-tick banner.
6. collision_In, levelDone_In and tick_In driven in IDLE, WIN and LOSS -> no state change. A start edge in WIN or LOSS -> screen 1, lives 3, level 1.
